uart_rx_fifo: RTL
=================

# uart_rx_fifo

UART receiver with a small receive FIFO, 8N1 format, LSB first. It samples the board RXD pin and presents received bytes plus status to the SoC memory-mapped IO read path; it is the receive-side counterpart of the TX emitter on the same IO bus. The CPU polls `o_valid` and the flags through the IO read mux and pops bytes with a one-cycle read strobe.

## Interface
- `clk_freq_hz`, default 10_000_000: system clock frequency.
- `baud_rate`, default 1_000_000: line rate.
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- Derived `CPB` = `clk_freq_hz/baud_rate` (integer division), clocks per bit; must be ≥4. Default CPB=10.
- `clk`  in  1  system clock; all logic on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `i_rx`  in  1  asynchronous serial input; idles high.
- `i_rd`  in  1  pop strobe; valid only when `o_valid`=1.
- `i_clr`  in  1  clears the sticky error flags.
- `o_data`  out  8  FIFO head byte; first-word fall-through.
- `o_valid`  out  1  FIFO not empty.
- `o_count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `o_overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `o_frame_err`  out  1  sticky: a stop bit was sampled low.

## Operation
- Synchronizer: two flops on `i_rx`, both reset to 1; output `rx_s`. All other logic uses only `rx_s`.
- Bit counter: counts down. When it reaches 0, the FSM samples `rx_s`.
- FSM states:
  - IDLE: `rx_s`=0 → START; counter loaded with CPB/2−1.
  - START: at counter 0, sample `rx_s`. If 0 → DATA, counter=CPB−1, bit index=0. If 1 → IDLE (glitch rejected, nothing recorded).
  - DATA: at each counter 0, shift `rx_s` into bit[index] (LSB first) and reload CPB−1. After the 8th bit → STOP.
  - STOP: at counter 0, sample `rx_s`.
    - If 1: push the byte and return to IDLE.
    - If 0: discard the byte, set `o_frame_err`, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then → IDLE. This prevents a break condition from producing 0x00 frames.
- Push on a full FIFO: byte dropped, `o_overrun` set, contents unchanged.
- Push and `i_rd` in the same cycle:
  - Both take effect.
  - When full, the pop frees a slot, so the push succeeds with no overrun.
  - When empty, `i_rd` is ignored and the push succeeds.
- `i_rd` while empty: ignored; no pointer or count change.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `o_count` is kept as a separate counter: +1 on push, −1 on pop, unchanged on push+pop.
- `i_clr` clears both sticky flags. If a flag-setting event occurs in the same cycle as `i_clr`, the flag ends up set (set wins).

## Timing
- Reset values:
  - FSM in IDLE; synchronizer flops at 1.
  - Pointers and `o_count` at 0; `o_valid`=0; `o_data`=0.
  - `o_overrun`=0; `o_frame_err`=0.
- Reset asserted mid-frame aborts the frame and empties the FIFO. The first frame after reset deasserts is received normally.
- Let edge E0 be the first clock edge that samples `i_rx`=0. The START sample, the 8 data samples and the STOP sample then fall CPB/2+2, CPB/2+2+k·CPB (k=1..8) and CPB/2+2+9·CPB edges after E0.
- `o_valid`/`o_count` update on the edge after the STOP sample: CPB/2+9·CPB+3 edges after E0 (98 at defaults).
- `o_data` reflects the new head one cycle after a pop. Flags assert on the edge after the triggering sample.
- The FSM is back in IDLE one cycle after the STOP sample, so back-to-back frames with a single stop bit are accepted.

## Test plan
- Send 0xA5 at default parameters → `o_valid` rises exactly 98 edges after E0, `o_data`=0xA5, `o_count`=1. Pulse `i_rd` → `o_valid`=0, `o_count`=0.
- Hold `i_rx` low for 3 cycles, then high → no push, no flags, FSM back in IDLE.
- Send 0x3C with stop bit 0, then hold the line low for 30 cycles, then send 0x55 → `o_frame_err`=1, only 0x55 is in the FIFO. Pulse `i_clr` → flag cleared.
- Send 9 back-to-back bytes 0x01..0x09 with no reads → `o_count`=8, `o_overrun`=1, pops return 0x01..0x08 in order.
- Fill the FIFO to 8, then assert `i_rd` in the same cycle the 9th byte is pushed → `o_count` stays 8, no overrun, last entry read back is the 9th byte.
- Assert `resetn` low during DATA of a frame → all outputs at reset values. After release, send 0xF0 → received correctly with exact timing.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : CPU-side IO read path of the UART receiver: pop/clear strobes,
//            FIFO head byte, occupancy and sticky status flags.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DEPTH = 8
);
    logic                       i_rd;
    logic                       i_clr;
    logic [7:0]                 o_data;
    logic                       o_valid;
    logic [$clog2(DEPTH+1)-1:0] o_count;
    logic                       o_overrun;
    logic                       o_frame_err;

    // CPU / bus side: issues strobes, reads data and status
    modport master (
        output i_rd, i_clr,
        input  o_data, o_valid, o_count, o_overrun, o_frame_err
    );

    // Receiver side: consumes strobes, presents data and status
    modport slave (
        input  i_rd, i_clr,
        output o_data, o_valid, o_count, o_overrun, o_frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver (LSB first) feeding a first-word-fall-through
//            receive FIFO with sticky overrun / framing-error flags.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int clk_freq_hz = 10_000_000,
    parameter int baud_rate   = 1_000_000,
    parameter int DEPTH       = 8
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    input  wire logic     i_rx,
    uart_rx_fifo_if.slave bus
);
    localparam int CPB   = clk_freq_hz / baud_rate;
    localparam int CNT_W = $clog2(CPB);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CPB - 1);
    localparam logic [CW-1:0]    COUNT_FULL = CW'(DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;
    logic             load_half;
    logic             count_active;
    logic             sample_data;
    logic             push_now;
    logic             frame_now;
    logic             push_req;
    logic             frame_req;
    logic [7:0]       push_data;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overrun;
    logic             frame_err;
    logic             fifo_full;
    logic             fifo_empty;
    logic             do_push;
    logic             do_pop;

    assign tick = (bit_cnt == '0);

    // Two-flop synchronizer; idles high so reset does not fake a start bit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Receive FSM next-state logic; all decisions are taken at mid-bit ticks
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (!rx_s) state_next = S_START;
            S_START:     if (tick)  state_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (tick && bit_idx == 3'd7) state_next = S_STOP;
            S_STOP:      if (tick)  state_next = rx_s ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s)  state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Receive FSM outputs: counter control, bit capture and frame-end events
    always_comb begin
        load_half    = 1'b0;
        count_active = 1'b0;
        sample_data  = 1'b0;
        push_now     = 1'b0;
        frame_now    = 1'b0;
        case (state)
            S_IDLE:  load_half = !rx_s;
            S_START: count_active = 1'b1;
            S_DATA: begin
                count_active = 1'b1;
                sample_data  = tick;
            end
            S_STOP: begin
                count_active = 1'b1;
                push_now     = tick && rx_s;
                frame_now    = tick && !rx_s;
            end
            default: ;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (load_half)         bit_cnt <= CNT_HALF;
            else if (count_active) bit_cnt <= tick ? CNT_FULL : bit_cnt - 1'b1;
            if (state == S_START)  bit_idx <= '0;
            if (sample_data) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

    // Frame-end events are registered so FIFO and flags act one edge after the stop sample
    always_ff @(posedge clk) begin
        if (!resetn) begin
            push_req  <= 1'b0;
            frame_req <= 1'b0;
            push_data <= '0;
        end else begin
            push_req  <= push_now;
            frame_req <= frame_now;
            if (push_now) push_data <= shift;
        end
    end

    assign fifo_full  = (count == COUNT_FULL);
    assign fifo_empty = (count == '0);
    assign do_pop     = bus.i_rd && !fifo_empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack
    assign do_push    = push_req && (!fifo_full || do_pop);

    // FIFO storage, wrapping pointers and independent occupancy counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Sticky error flags; a same-cycle setting event overrides the clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (bus.i_clr) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (push_req && !do_push) overrun   <= 1'b1;
            if (frame_req)            frame_err <= 1'b1;
        end
    end

    assign bus.o_data      = mem[rd_ptr];
    assign bus.o_valid     = !fifo_empty;
    assign bus.o_count     = count;
    assign bus.o_overrun   = overrun;
    assign bus.o_frame_err = frame_err;

endmodule
`default_nettype wire
